tmds_period_sched: RTL



---
 rtl/tmds_period_sched.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tmds_period_sched.sv
// tmds_period_sched: delays timing and pixels by PRE_LEN+GB_LEN+1 clocks and marks preamble/guard
// periods ahead of active video. HDMI period insertion is built only with TMDS_HDMI_PERIODS_EN.
module tmds_period_sched #(
    parameter int PRE_LEN = 8,
    parameter int GB_LEN  = 2,
    parameter int DATA_W  = 24
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              de_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic [DATA_W-1:0] pix_i,
    input  logic              err_clr_i,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [DATA_W-1:0] pix_o,
    output logic [1:0]        mode_o,
    output logic [3:0]        ctl_o,
    output logic              err_o
);
    localparam int L       = PRE_LEN + GB_LEN + 1;
    localparam int CNT_MAX = (PRE_LEN > GB_LEN) ? PRE_LEN : GB_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [1:0] MODE_CTRL  = 2'd0;
    localparam logic [1:0] MODE_PRE   = 2'd1;
    localparam logic [1:0] MODE_GUARD = 2'd2;
    localparam logic [1:0] MODE_VIDEO = 2'd3;

    logic [L-1:0]      de_dl;
    logic [L-1:0]      hs_dl;
    logic [L-1:0]      vs_dl;
    logic [DATA_W-1:0] pix_dl [L];
    logic              de_next;
    logic [1:0]        mode_nx;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            de_dl <= '0;
            hs_dl <= '0;
            vs_dl <= '0;
            for (int i = 0; i < L; i++) pix_dl[i] <= '0;
        end else begin
            de_dl     <= {de_dl[L-2:0], de_i};
            hs_dl     <= {hs_dl[L-2:0], hsync_i};
            vs_dl     <= {vs_dl[L-2:0], vsync_i};
            pix_dl[0] <= pix_i;
            for (int i = 1; i < L; i++) pix_dl[i] <= pix_dl[i-1];
        end
    end

    // de_next is the value de_o takes on the coming edge; mode is registered alongside it.
    assign de_next = de_dl[L-2];
    assign de_o    = de_dl[L-1];
    assign hsync_o = hs_dl[L-1];
    assign vsync_o = vs_dl[L-1];
    assign pix_o   = pix_dl[L-1];

`ifdef TMDS_HDMI_PERIODS_EN
    typedef enum logic [1:0] {S_CTRL, S_PRE, S_GUARD, S_VIDEO} state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             de_q;
    logic             rise;
    logic             err_nx;
    logic [3:0]       ctl_nx;

    assign rise = de_i & ~de_q;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state  <= S_CTRL;
            cnt    <= '0;
            de_q   <= 1'b0;
            mode_o <= MODE_CTRL;
            ctl_o  <= 4'b0000;
            err_o  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            de_q   <= de_i;
            mode_o <= mode_nx;
            ctl_o  <= ctl_nx;
            err_o  <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_CTRL: begin
                if (rise) begin
                    state_nx = S_PRE;
                    cnt_nx   = '0;
                end
            end
            S_PRE: begin
                if (cnt == CNT_W'(PRE_LEN - 1)) begin
                    state_nx = S_GUARD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_GUARD: begin
                if (cnt == CNT_W'(GB_LEN - 1)) begin
                    state_nx = S_VIDEO;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (!de_next) state_nx = S_CTRL;
            end
        endcase

        // Delayed video always wins over the sequencer.
        if (de_next) begin
            mode_nx = MODE_VIDEO;
        end else begin
            case (state_nx)
                S_PRE:   mode_nx = MODE_PRE;
                S_GUARD: mode_nx = MODE_GUARD;
                default: mode_nx = MODE_CTRL;
            endcase
        end
        ctl_nx = (mode_nx == MODE_PRE) ? 4'b0001 : 4'b0000;

        // A rise with the sequencer still busy is a too-short control gap; set beats clear.
        err_nx = err_o;
        if (rise && (state != S_CTRL)) begin
            err_nx = 1'b1;
        end else if (err_clr_i) begin
            err_nx = 1'b0;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = err_clr_i;
    assign mode_nx    = de_next ? MODE_VIDEO : MODE_CTRL;
    assign ctl_o      = 4'b0000;
    assign err_o      = 1'b0;

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            mode_o <= MODE_CTRL;
        end else begin
            mode_o <= mode_nx;
        end
    end
`endif

endmodule
